// File: rtl/nock_pkg.sv
// nock_pkg: shared definitions for the noun memory slice.
//   CELL_W / ADDR_W : default field width and word-address width
//   NIL             : all-ones sentinel cell value
//   TAG_*           : noun tag encodings (atom is any 3'b0xx)
//   port_id_e       : requester identity on the noun memory arbiter
//   arb_state_e     : arbiter FSM states
package nock_pkg;

    localparam int CELL_W = 32;
    localparam int ADDR_W = 8;

    localparam logic [31:0] NIL = 32'hFFFF_FFFF;

    localparam logic [2:0] TAG_CELL = 3'b111;
    localparam logic [2:0] TAG_OP   = 3'b101;
    localparam logic [2:0] TAG_ATOM = 3'b000;

    typedef enum logic {
        PORT_T = 1'b0,
        PORT_H = 1'b1
    } port_id_e;

    typedef enum logic {
        ARB_RR     = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Atoms occupy the whole 3'b0xx half of the tag space.
    function automatic logic is_atom_tag(input logic [2:0] tag);
        return ~tag[2];
    endfunction

endpackage

// File: rtl/noun_mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick, purely combinational.
//   req_t, req_h : requests from the two contenders
//   last         : port that won the most recent transfer
//   gnt_t, gnt_h : one-hot winner (both 0 when nobody requests)
// A lone requester always wins; on contention the port not named by
// `last` wins.
module rr_pick2
    import nock_pkg::*;
(
    input  logic     req_t,
    input  logic     req_h,
    input  port_id_e last,
    output logic     gnt_t,
    output logic     gnt_h
);

    assign gnt_t = req_t & (~req_h | (last == PORT_H));
    assign gnt_h = req_h & (~req_t | (last == PORT_T));

endmodule

// File: rtl/noun_mem_arbiter.sv
// noun_mem_arbiter: shares the single-port noun memory ({hed,tel} words)
// between the traversal engine (T) and the host loader/debug port (H).
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   t_* / h_*              : per-port req, we[1]=hed/we[0]=tel (00 = read),
//                            addr, wdata; gnt, rvalid, rdata back
//   h_lock / locked        : host lock request / arbiter is in LOCKED state
//   mem_*                  : memory macro strobe, enables, address, data;
//                            mem_rdata returns one cycle after mem_en
//
// Handshake: a transfer happens in any cycle where req & gnt; grant is
// combinational from state and req, so a transfer costs zero wait cycles
// when the port is eligible. A read transfer raises that port's rvalid
// exactly one cycle later, with rdata valid only while rvalid is high.
module noun_mem_arbiter
    import nock_pkg::*;
#(
    parameter int ADDR_W = nock_pkg::ADDR_W,
    parameter int CELL_W = nock_pkg::CELL_W
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                t_req,
    input  logic [1:0]          t_we,
    input  logic [ADDR_W-1:0]   t_addr,
    input  logic [2*CELL_W-1:0] t_wdata,
    output logic                t_gnt,
    output logic                t_rvalid,
    output logic [2*CELL_W-1:0] t_rdata,

    input  logic                h_req,
    input  logic [1:0]          h_we,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [2*CELL_W-1:0] h_wdata,
    output logic                h_gnt,
    output logic                h_rvalid,
    output logic [2*CELL_W-1:0] h_rdata,

    input  logic                h_lock,
    output logic                locked,

    output logic                mem_en,
    output logic [1:0]          mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [2*CELL_W-1:0] mem_wdata,
    input  logic [2*CELL_W-1:0] mem_rdata
);

    arb_state_e state;
    port_id_e   last;
    logic       t_rvalid_q;
    logic       h_rvalid_q;

    logic       pick_t;
    logic       pick_h;
    logic       lock_hold;
    port_id_e   eff_last;
    logic       t_xfer;
    logic       h_xfer;

    // While locked the host keeps the memory. The cycle h_lock drops is
    // arbitrated as RR with last=H so a waiting T gets in first.
    assign lock_hold = (state == ARB_LOCKED) & h_lock;
    assign eff_last  = (state == ARB_LOCKED) ? PORT_H : last;

    rr_pick2 u_pick (
        .req_t (t_req),
        .req_h (h_req),
        .last  (eff_last),
        .gnt_t (pick_t),
        .gnt_h (pick_h)
    );

    always_comb begin
        t_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!reset) begin
            if (lock_hold) begin
                h_gnt = h_req;
            end else begin
                t_gnt = pick_t;
                h_gnt = pick_h;
            end
        end
    end

    assign t_xfer = t_req & t_gnt;
    assign h_xfer = h_req & h_gnt;

    always_comb begin
        mem_en    = t_xfer | h_xfer;
        mem_we    = 2'b00;
        mem_addr  = t_addr;
        mem_wdata = t_wdata;
        if (h_xfer) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end else if (t_xfer) begin
            mem_we    = t_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_RR;
            last       <= PORT_H;
            t_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
        end else begin
            t_rvalid_q <= t_xfer & (t_we == 2'b00);
            h_rvalid_q <= h_xfer & (h_we == 2'b00);

            if (h_xfer) begin
                last <= PORT_H;
            end else if (t_xfer) begin
                last <= PORT_T;
            end

            case (state)
                ARB_RR: begin
                    if (h_xfer && h_lock) begin
                        state <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (!h_lock) begin
                        state <= ARB_RR;
                    end
                end
                default: state <= ARB_RR;
            endcase
        end
    end

    assign locked = (state == ARB_LOCKED);

    // Gating with reset keeps a read that was in flight when reset hits
    // from ever being seen by the requester.
    assign t_rvalid = t_rvalid_q & ~reset;
    assign h_rvalid = h_rvalid_q & ~reset;

    assign t_rdata = mem_rdata;
    assign h_rdata = mem_rdata;

endmodule

// File: doc/noun_mem_arbiter.md
# noun_mem_arbiter

Two-requester arbiter for the single-port noun memory, where each word holds a head/tail pair. It shares the memory between two requesters: the tree-traversal engine (T port) and the host loader/debug port (H port). Fair round-robin applies in normal operation. The host can also lock the memory for atomic multi-word load or inspect sequences. It sits between both requesters and the memory macro, and owns every memory enable.

## Interface
- ADDR_W, 8, noun memory address width (word index)
- CELL_W, 32, width of one head or tail field; memory word is 2*CELL_W as {hed,tel}
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- t_req, h_req  in  1  access request
- t_we, h_we  in  2  field write enables: [1]=hed, [0]=tel; 2'b00 = read
- t_addr, h_addr  in  ADDR_W  word address
- t_wdata, h_wdata  in  2*CELL_W  {hed,tel} write data
- t_gnt, h_gnt  out  1  grant (combinational from state + req); transfer = req&gnt
- t_rvalid, h_rvalid  out  1  read data valid (registered)
- t_rdata, h_rdata  out  2*CELL_W  read data; valid only with rvalid
- h_lock  in  1  host lock request
- locked  out  1  arbiter is in LOCKED state
- mem_en  out  1  memory access strobe
- mem_we  out  2  field write enables to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  2*CELL_W  memory write data
- mem_rdata  in  2*CELL_W  memory read data, 1-cycle latency after mem_en

## Operation
- States: RR, LOCKED.
- RR state:
  - Request on one port only: that port is granted.
  - Both ports request: the port not named by the `last` pointer wins.
  - `last` updates to the winner on every transfer.
- RR → LOCKED: on a host transfer while h_lock=1.
- LOCKED state:
  - Only H is granted; t_gnt=0 regardless of t_req.
  - LOCKED → RR on the first cycle with h_lock=0. That cycle is arbitrated as RR with last=H, so T wins if it requests.
- Memory drive:
  - mem_en=1 exactly when a transfer occurs.
  - mem_addr, mem_we and mem_wdata are muxed from the granted port.
  - With no transfer, mem_we=0 and mem_en=0.
- Read return:
  - On a transfer with we=2'b00, the granted port's rvalid asserts the next cycle, with rdata=mem_rdata.
  - Writes produce no rvalid.
  - Partial writes leave the unselected field unchanged; the memory macro handles byte-lane style enables.
- rdata outputs are a direct pass-through of mem_rdata. The rvalid source tag (T/H) is registered per access.
- One transfer per cycle. Back-to-back transfers are permitted, so the bus is fully pipelined.

## Timing
- Reset values:
  - state=RR, last=H (T has priority first), locked=0.
  - t_rvalid=h_rvalid=0, mem_en=0, mem_we=0.
- Grant latency: 0 cycles (same cycle as req when eligible).
- Read latency: 1 cycle from transfer to rvalid.
- Reset asserted with a read in flight: the pending rvalid is suppressed and never emitted.
- A requester not granted holds req, addr, we and wdata stable until it is granted. The arbiter must not depend on this but verification checks it.
- Read-after-write to the same address in consecutive cycles returns the new data (write-first memory).
- h_lock asserted without h_req has no effect in RR; the lock is taken only on a host transfer.
- h_lock dropped while h_rvalid is pending: rvalid is still delivered to H.
- locked output is registered; it rises the cycle after the locking transfer.

## Structure
- The shared package nock_pkg holds:
  - CELL_W, ADDR_W defaults.
  - nil constant 32'hFFFF_FFFF.
  - noun tag encodings (cell 3'b111, op 3'b101, atom 3'b0xx).
  - Port-ID enum {PORT_T, PORT_H}.
  - Arbiter state enum {ARB_RR, ARB_LOCKED}.
- One sub-module, rr_pick2: a two-way round-robin pick from {req_t, req_h, last} → winner. Pure combinational, reused by future multi-engine arbiters.

## Test plan
- Reset, then t_req alone, read addr 0x01 (memory {32'hE0000002,32'h00000003}) → t_gnt=1 the same cycle, t_rvalid=1 the next cycle with t_rdata=64'hE0000002_00000003; h_rvalid stays 0.
- Both ports request continuously for 4 cycles → grants alternate T,H,T,H; mem_addr alternates accordingly.
- Host write h_we=2'b10 addr 0x02 hed=32'h00000007, then T reads 0x02 the next cycle → rdata {32'h00000007, old tel 32'h00000005}.
- Host transfer with h_lock=1, then t_req held for 3 cycles while the host does 3 transfers → t_gnt=0 throughout, locked=1. On h_lock=0, T is granted that same cycle.
- T read issued, reset asserted the next cycle → t_rvalid stays 0; all outputs return to reset values.
- Idle cycles with no req → mem_en=0, mem_we=0, no rvalid on either port.
